// File: rtl/hbm_write_engine_pkg.sv
// Shared AXI4 constants and helpers for the HBM write traffic engine.
package hbm_write_engine_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // AxSIZE encoding for a full-width beat of dw bits.
    function automatic logic [2:0] axi_size(input int dw);
        return 3'($clog2(dw / 8));
    endfunction

endpackage

// File: rtl/hbm_wdata_gen.sv
// W-channel issuer: counts beats across the whole run, drives the beat-index
// data pattern and WLAST, and flags done after the final beat is accepted.
module hbm_wdata_gen #(
    parameter int DW          = 256,
    parameter int BURST_BEATS = 64,
    parameter int NUM_BURSTS  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic          i_wready,
    output logic [DW-1:0] o_wdata,
    output logic          o_wlast,
    output logic          o_wvalid,
    output logic          o_done
);

    localparam logic [31:0] TOTAL    = 32'(NUM_BURSTS * BURST_BEATS);
    localparam logic [8:0]  LAST_IDX = 9'(BURST_BEATS - 1);

    logic [31:0] r_beat;
    logic [8:0]  r_idx;
    logic        r_wvalid;
    logic        r_wlast;
    logic        r_done;
    logic [8:0]  w_idx_nxt;

    always_comb begin
        w_idx_nxt = r_idx + 9'd1;
        if (r_idx == LAST_IDX) w_idx_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat   <= '0;
            r_idx    <= '0;
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_beat   <= '0;
            r_idx    <= '0;
            r_wvalid <= 1'b1;
            r_wlast  <= (LAST_IDX == 9'd0);
            r_done   <= 1'b0;
        end else if (r_wvalid && i_wready) begin
            r_beat  <= r_beat + 32'd1;
            r_idx   <= w_idx_nxt;
            r_wlast <= (w_idx_nxt == LAST_IDX);
            if (r_beat == TOTAL - 32'd1) begin
                r_wvalid <= 1'b0;
                r_wlast  <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    assign o_wdata  = {(DW/32){r_beat}};
    assign o_wlast  = r_wlast;
    assign o_wvalid = r_wvalid;
    assign o_done   = r_done;

endmodule

// File: rtl/hbm_write_engine.sv
// HBM write traffic stage: on start, issues NUM_BURSTS INCR bursts to one
// pseudo-channel and measures the busy time for bandwidth reporting.
module hbm_write_engine
    import hbm_write_engine_pkg::*;
#(
    parameter int             DW          = 256,
    parameter int             AW          = 34,
    parameter logic [AW-1:0]  BASE_ADDR   = '0,
    parameter int             BURST_BEATS = 64,
    parameter int             NUM_BURSTS  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_write,
    output logic            write_busy,
    output logic [31:0]     write_time,
    output logic            write_error,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY
);

    localparam logic [AW-1:0] BURST_BYTES = AW'(BURST_BEATS * DW / 8);
    localparam logic [16:0]   NB          = 17'(NUM_BURSTS);

    state_t        r_state;
    logic          r_busy;
    logic [31:0]   r_time;
    logic          r_err;
    logic          r_awvalid;
    logic [AW-1:0] r_awaddr;
    logic [16:0]   r_aw_cnt;
    logic [16:0]   r_b_cnt;
    logic          w_start;
    logic          w_wdone;

    assign w_start = start_write && (r_state == ST_IDLE);

    hbm_wdata_gen #(
        .DW          (DW),
        .BURST_BEATS (BURST_BEATS),
        .NUM_BURSTS  (NUM_BURSTS)
    ) u_wdata_gen (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_wready (M_AXI_WREADY),
        .o_wdata  (M_AXI_WDATA),
        .o_wlast  (M_AXI_WLAST),
        .o_wvalid (M_AXI_WVALID),
        .o_done   (w_wdone)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_time    <= '0;
            r_err     <= 1'b0;
            r_awvalid <= 1'b0;
            r_awaddr  <= BASE_ADDR;
            r_aw_cnt  <= '0;
            r_b_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_write) begin
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                        r_time    <= '0;
                        r_err     <= 1'b0;
                        r_awvalid <= 1'b1;
                        r_awaddr  <= BASE_ADDR;
                        r_aw_cnt  <= '0;
                        r_b_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (r_time != 32'hFFFF_FFFF) r_time <= r_time + 32'd1;
                    // Address advances only once the current burst is accepted.
                    if (r_awvalid && M_AXI_AWREADY) begin
                        r_aw_cnt <= r_aw_cnt + 17'd1;
                        if (r_aw_cnt == NB - 17'd1) r_awvalid <= 1'b0;
                        else                        r_awaddr  <= r_awaddr + BURST_BYTES;
                    end
                    if (M_AXI_BVALID && (r_b_cnt != NB)) begin
                        r_b_cnt <= r_b_cnt + 17'd1;
                        if (M_AXI_BRESP != RESP_OKAY) r_err <= 1'b1;
                    end
                    if ((r_b_cnt == NB) && w_wdone) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign write_busy    = r_busy;
    assign write_time    = r_time;
    assign write_error   = r_err;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWLEN   = 8'(BURST_BEATS - 1);
    assign M_AXI_AWSIZE  = axi_size(DW);
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_BREADY  = 1'b1;

endmodule

// File: tb/tb_hbm_write_engine.sv
// Self-checking bench: randomized slave throttling around a queue-based
// reference of the expected AW addresses, beat patterns and timing.
module tb_hbm_write_engine;

    localparam int DW    = 256;
    localparam int AW    = 34;
    localparam int BB    = 64;
    localparam int NB    = 16;
    localparam int TOTAL = NB * BB;
    localparam int IDEAL = TOTAL + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic           start0, busy0, err0, awvalid0, awready0, wlast0, wvalid0, wready0, bvalid0, bready0;
    logic [31:0]    time0, wstrb0;
    logic [AW-1:0]  awaddr0;
    logic [7:0]     awlen0;
    logic [2:0]     awsize0;
    logic [1:0]     awburst0, bresp0;
    logic [DW-1:0]  wdata0;

    logic           start1, busy1, err1, awvalid1, awready1, wlast1, wvalid1, wready1, bvalid1, bready1;
    logic [31:0]    time1, wstrb1;
    logic [AW-1:0]  awaddr1;
    logic [7:0]     awlen1;
    logic [2:0]     awsize1;
    logic [1:0]     awburst1, bresp1;
    logic [DW-1:0]  wdata1;

    hbm_write_engine #(.DW(DW), .AW(AW), .BASE_ADDR('0), .BURST_BEATS(BB), .NUM_BURSTS(NB)) dut0 (
        .clk(clk), .reset(reset), .start_write(start0), .write_busy(busy0), .write_time(time0),
        .write_error(err0), .M_AXI_AWADDR(awaddr0), .M_AXI_AWLEN(awlen0), .M_AXI_AWSIZE(awsize0),
        .M_AXI_AWBURST(awburst0), .M_AXI_AWVALID(awvalid0), .M_AXI_AWREADY(awready0),
        .M_AXI_WDATA(wdata0), .M_AXI_WSTRB(wstrb0), .M_AXI_WLAST(wlast0), .M_AXI_WVALID(wvalid0),
        .M_AXI_WREADY(wready0), .M_AXI_BRESP(bresp0), .M_AXI_BVALID(bvalid0), .M_AXI_BREADY(bready0));

    hbm_write_engine #(.DW(DW), .AW(AW), .BASE_ADDR(34'h1000), .BURST_BEATS(1), .NUM_BURSTS(1)) dut1 (
        .clk(clk), .reset(reset), .start_write(start1), .write_busy(busy1), .write_time(time1),
        .write_error(err1), .M_AXI_AWADDR(awaddr1), .M_AXI_AWLEN(awlen1), .M_AXI_AWSIZE(awsize1),
        .M_AXI_AWBURST(awburst1), .M_AXI_AWVALID(awvalid1), .M_AXI_AWREADY(awready1),
        .M_AXI_WDATA(wdata1), .M_AXI_WSTRB(wstrb1), .M_AXI_WLAST(wlast1), .M_AXI_WVALID(wvalid1),
        .M_AXI_WREADY(wready1), .M_AXI_BRESP(bresp1), .M_AXI_BVALID(bvalid1), .M_AXI_BREADY(bready1));

    int vectors = 0;
    int miscompares = 0;

    // Slave/monitor state for dut0; knobs below are written only by the test tasks.
    int              cyc = 0;
    int              aw_block_until = 0;
    bit              w_rand = 1'b0;
    int              bad_b = -1;
    int              b_total = 0;
    int              bq_n = 0;
    int              busy_cyc = 0;
    int              stall_err = 0;
    bit              aw_stall = 1'b0, w_stall = 1'b0;
    logic [AW-1:0]   aw_prev;
    logic [DW-1:0]   wd_prev;
    logic            wl_prev;
    logic [AW-1:0]   aw_log[$];
    logic [DW-1:0]   wd_log[$];
    logic            wl_log[$];

    initial begin
        awready0 = 1'b0; wready0 = 1'b0; bvalid0 = 1'b0; bresp0 = 2'b00;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                bq_n = 0; aw_stall = 1'b0; w_stall = 1'b0;
                awready0 = 1'b0; wready0 = 1'b0; bvalid0 = 1'b0; bresp0 = 2'b00;
            end else begin
                awready0 = (cyc >= aw_block_until);
                wready0  = w_rand ? cyc[0] ^ ($urandom_range(0, 3) == 0) : 1'b1;
                if (bq_n > 0) begin
                    bvalid0 = 1'b1;
                    bresp0  = (b_total == bad_b) ? 2'b10 : 2'b00;
                    b_total++;
                    bq_n--;
                end else begin
                    bvalid0 = 1'b0;
                    bresp0  = 2'b00;
                end
                if (aw_stall && (!awvalid0 || awaddr0 !== aw_prev)) stall_err++;
                if (w_stall && (!wvalid0 || wdata0 !== wd_prev || wlast0 !== wl_prev)) stall_err++;
                aw_stall = awvalid0 && !awready0;
                w_stall  = wvalid0 && !wready0;
                aw_prev = awaddr0; wd_prev = wdata0; wl_prev = wlast0;
                if (awvalid0 && awready0) aw_log.push_back(awaddr0);
                if (wvalid0 && wready0) begin
                    wd_log.push_back(wdata0);
                    wl_log.push_back(wlast0);
                    if (wlast0) bq_n++;
                end
                if (busy0) busy_cyc++;
            end
        end
    end

    // Ideal slave for dut1.
    logic            b1_pend;
    logic [AW-1:0]   aw1_log[$];
    logic            wl1_log[$];
    logic [DW-1:0]   wd1_log[$];

    initial begin
        awready1 = 1'b0; wready1 = 1'b0; bvalid1 = 1'b0; bresp1 = 2'b00; b1_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                awready1 = 1'b0; wready1 = 1'b0; bvalid1 = 1'b0; b1_pend = 1'b0;
            end else begin
                awready1 = 1'b1; wready1 = 1'b1;
                bvalid1 = b1_pend; b1_pend = 1'b0;
                if (awvalid1 && awready1) aw1_log.push_back(awaddr1);
                if (wvalid1 && wready1) begin
                    wl1_log.push_back(wlast1);
                    wd1_log.push_back(wdata1);
                    if (wlast1) b1_pend = 1'b1;
                end
            end
        end
    end

    // Reference: burst k at k*bytes-per-burst, beat b carries b in every 32-bit lane.
    function automatic int model_errs(input int awb, input int wb);
        int e = 0;
        logic [31:0] bv;
        logic [DW-1:0] want_d;
        logic want_l;
        if (aw_log.size() - awb != NB) e++;
        for (int k = 0; k < NB && awb + k < aw_log.size(); k++)
            if (aw_log[awb + k] !== AW'(k * BB * DW / 8)) e++;
        if (wd_log.size() - wb != TOTAL) e++;
        for (int b = 0; b < TOTAL && wb + b < wd_log.size(); b++) begin
            bv = b;
            want_d = {(DW/32){bv}};
            want_l = ((b % BB) == BB - 1);
            if (wd_log[wb + b] !== want_d) e++;
            if (wl_log[wb + b] !== want_l) e++;
        end
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy0 && n < 20000) begin
            step();
            n++;
        end
        vectors++;
        if (busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_timeout: write_busy=%0b want 0", nm, busy0);
        end
    endtask

    task automatic test_reset();
        logic [31:0] ones32;
        ones32 = '1;
        vectors++;
        if ({busy0, err0, awvalid0, wvalid0, wlast0} !== 5'b0 || time0 !== 32'd0 || awaddr0 !== '0) begin
            miscompares++;
            $display("FAIL reset0: busy=%0b err=%0b awv=%0b wv=%0b wl=%0b time=%0d addr=%h want all 0",
                     busy0, err0, awvalid0, wvalid0, wlast0, time0, awaddr0);
        end
        vectors++;
        if (awlen0 !== 8'd63 || awsize0 !== 3'd5 || awburst0 !== 2'b01 || wstrb0 !== ones32 || bready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL const0: len=%0d size=%0d burst=%0d strb=%h bready=%0b want 63 5 1 ffffffff 1",
                     awlen0, awsize0, awburst0, wstrb0, bready0);
        end
        vectors++;
        if (busy1 !== 1'b0 || err1 !== 1'b0 || time1 !== 32'd0 || awaddr1 !== 34'h1000 || awlen1 !== 8'd0 ||
            awsize1 !== 3'd5 || awburst1 !== 2'b01 || wstrb1 !== ones32 || bready1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset1: busy=%0b err=%0b time=%0d addr=%h len=%0d want 0 0 0 1000 0",
                     busy1, err1, time1, awaddr1, awlen1);
        end
    endtask

    task automatic test_ideal();
        int awb = aw_log.size(), wb = wd_log.size(), bc = busy_cyc, e;
        start_run();
        vectors++;
        if ({busy0, awvalid0, wvalid0} !== 3'b111 || time0 !== 32'd0 || awaddr0 !== '0) begin
            miscompares++;
            $display("FAIL start_latency: busy=%0b awv=%0b wv=%0b time=%0d addr=%h want 1 1 1 0 0",
                     busy0, awvalid0, wvalid0, time0, awaddr0);
        end
        wait_idle("ideal");
        e = model_errs(awb, wb);
        vectors++;
        if (e !== 0) begin miscompares++; $display("FAIL ideal_stream: %0d bad entries want 0", e); end
        vectors++;
        if (time0 !== 32'(IDEAL) || err0 !== 1'b0) begin
            miscompares++;
            $display("FAIL ideal_time: time=%0d err=%0b want %0d 0", time0, err0, IDEAL);
        end
        vectors++;
        if (busy_cyc - bc !== IDEAL) begin
            miscompares++;
            $display("FAIL ideal_busy: busy cycles=%0d want %0d", busy_cyc - bc, IDEAL);
        end
    endtask

    task automatic test_stall();
        int awb = aw_log.size(), wb = wd_log.size(), bc = busy_cyc, se = stall_err, e;
        aw_block_until = cyc + 50;
        w_rand = 1'b1;
        start_run();
        wait_idle("stall");
        w_rand = 1'b0;
        e = model_errs(awb, wb);
        vectors++;
        if (e !== 0) begin miscompares++; $display("FAIL stall_stream: %0d bad entries want 0", e); end
        vectors++;
        if (stall_err - se !== 0) begin
            miscompares++;
            $display("FAIL stall_stable: %0d unstable cycles want 0", stall_err - se);
        end
        vectors++;
        if (time0 !== 32'(busy_cyc - bc) || time0 <= 32'(IDEAL)) begin
            miscompares++;
            $display("FAIL stall_time: time=%0d want %0d (> %0d)", time0, busy_cyc - bc, IDEAL);
        end
    endtask

    task automatic test_error();
        int awb = aw_log.size(), wb = wd_log.size(), e;
        logic [31:0] held;
        bad_b = b_total + 5;
        start_run();
        wait_idle("error");
        e = model_errs(awb, wb);
        vectors++;
        if (err0 !== 1'b1 || e !== 0) begin
            miscompares++;
            $display("FAIL slverr: err=%0b stream errs=%0d want 1 0", err0, e);
        end
        held = time0;
        repeat (5) step();
        vectors++;
        if (time0 !== held || err0 !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_hold: time=%0d err=%0b want %0d 1", time0, err0, held);
        end
        bad_b = -1;
        start_run();
        vectors++;
        if (err0 !== 1'b0 || time0 !== 32'd0) begin
            miscompares++;
            $display("FAIL restart_clear: err=%0b time=%0d want 0 0", err0, time0);
        end
        wait_idle("error_rerun");
        vectors++;
        if (err0 !== 1'b0 || time0 !== 32'(IDEAL)) begin
            miscompares++;
            $display("FAIL rerun: err=%0b time=%0d want 0 %0d", err0, time0, IDEAL);
        end
    endtask

    task automatic test_back_to_back();
        int awb = aw_log.size(), wb = wd_log.size(), e;
        start_run();
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(50, 250)) step();
            start_run();
        end
        wait_idle("multistart");
        e = model_errs(awb, wb);
        vectors++;
        if (e !== 0 || time0 !== 32'(IDEAL)) begin
            miscompares++;
            $display("FAIL multistart: stream errs=%0d time=%0d want 0 %0d", e, time0, IDEAL);
        end
        repeat (3) step();
        vectors++;
        if (busy0 !== 1'b0 || aw_log.size() - awb !== NB) begin
            miscompares++;
            $display("FAIL multistart_extra: busy=%0b bursts=%0d want 0 %0d", busy0, aw_log.size() - awb, NB);
        end
    endtask

    task automatic test_reset_mid();
        int wb = wd_log.size(), n = 0, awb, e;
        start_run();
        while (wd_log.size() - wb < 300 && n < 5000) begin step(); n++; end
        vectors++;
        if (wd_log.size() - wb < 300) begin
            miscompares++;
            $display("FAIL reach_beat300: beats=%0d want 300", wd_log.size() - wb);
        end
        reset = 1'b1;
        step();
        vectors++;
        if ({busy0, awvalid0, wvalid0, wlast0, err0} !== 5'b0 || time0 !== 32'd0 || awaddr0 !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: busy=%0b awv=%0b wv=%0b wl=%0b time=%0d addr=%h want all 0",
                     busy0, awvalid0, wvalid0, wlast0, time0, awaddr0);
        end
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        reset = 1'b0;
        step();
        vectors++;
        if (busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_reset: busy=%0b want 0", busy0);
        end
        awb = aw_log.size();
        wb = wd_log.size();
        start_run();
        wait_idle("post_reset");
        e = model_errs(awb, wb);
        vectors++;
        if (e !== 0 || time0 !== 32'(IDEAL)) begin
            miscompares++;
            $display("FAIL post_reset_run: stream errs=%0d time=%0d want 0 %0d", e, time0, IDEAL);
        end
    endtask

    task automatic test_single_beat();
        int awb = aw1_log.size(), wb = wl1_log.size(), n = 0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        while (busy1 && n < 100) begin step(); n++; end
        vectors++;
        if (busy1 !== 1'b0 || time1 !== 32'd3 || err1 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_time: busy=%0b time=%0d err=%0b want 0 3 0", busy1, time1, err1);
        end
        vectors++;
        if (aw1_log.size() - awb !== 1 || wl1_log.size() - wb !== 1) begin
            miscompares++;
            $display("FAIL single_count: aw=%0d w=%0d want 1 1", aw1_log.size() - awb, wl1_log.size() - wb);
        end else begin
            vectors++;
            if (aw1_log[awb] !== 34'h1000 || wl1_log[wb] !== 1'b1 || wd1_log[wb] !== '0) begin
                miscompares++;
                $display("FAIL single_beat: addr=%h wlast=%0b data=%h want 1000 1 0",
                         aw1_log[awb], wl1_log[wb], wd1_log[wb]);
            end
        end
    endtask

    initial begin
        start0 = 1'b0;
        start1 = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        test_reset();
        reset = 1'b0;
        step();
        test_ideal();
        test_stall();
        test_error();
        test_back_to_back();
        test_reset_mid();
        test_single_beat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hbm_write_engine.md
Name: hbm_write_engine

Overview:
- Traffic stage that consumes the `start_write` pulse from the AXI4-Lite control block.
- Drives a fixed-size sequence of AXI4 INCR write bursts into one HBM pseudo-channel.
- Reports `write_busy` and the elapsed cycle count `write_time` back to the control block for bandwidth measurement.
- One instance per HBM port under test: instance 0 feeds `write_time_0`, instance 1 feeds `write_time_1`.

Parameters:
- DW, 256, AXI data width in bits; must be a power of 2, ≥32.
- AW, 34, AXI address width in bits.
- BASE_ADDR, 0, first burst address; must be aligned to BURST_BEATS*DW/8.
- BURST_BEATS, 64, beats per burst, 1..256; bytes per burst must not exceed 4096.
- NUM_BURSTS, 16, bursts per run, 1..65535.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start_write  in  1  single-cycle start pulse.
- write_busy  out  1  high while a run is in progress.
- write_time  out  32  cycles counted during the last run.
- write_error  out  1  sticky; a non-OKAY BRESP was seen in the current or last run.
- M_AXI_AWADDR  out  AW  burst address.
- M_AXI_AWLEN  out  8  constant BURST_BEATS-1.
- M_AXI_AWSIZE  out  3  constant log2(DW/8).
- M_AXI_AWBURST  out  2  constant 2'b01 (INCR).
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  DW  data pattern.
- M_AXI_WSTRB  out  DW/8  all ones.
- M_AXI_WLAST  out  1  last beat of a burst.
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1  constant 1.

Behaviour:
- Reset values: write_busy=0, write_time=0, write_error=0, AWVALID=0, WVALID=0, WLAST=0, AWADDR=BASE_ADDR, all counters 0.
- Top FSM states:
  - IDLE: on start_write=1 → RUN next cycle. On that edge: write_time←0, write_error←0, burst/beat/response counters←0.
  - RUN: write_busy=1. Returns to IDLE the cycle after the NUM_BURSTS-th B handshake.
- start_write while in RUN is ignored. A pulse coincident with reset is ignored.
- Latency: start_write sampled at edge N → write_busy, AWVALID and WVALID all high after edge N.
- write_time:
  - Increments by 1 on every edge where write_busy=1.
  - Saturates at 32'hFFFFFFFF; no wrap.
  - Holds its value in IDLE until the next start.
  - Ideal slave (AWREADY=WREADY=1, BVALID one cycle after WLAST): write_time = NUM_BURSTS*BURST_BEATS + 2.
- AW issuer (independent sub-FSM):
  - Presents AWVALID with AWADDR = BASE_ADDR + k*BURST_BEATS*DW/8 for burst k.
  - AWVALID/AWADDR are held stable until AWREADY.
  - After NUM_BURSTS handshakes, AWVALID=0 for the rest of the run.
- W issuer (independent, does not wait for AW; AXI4 permits data before address):
  - Beat counter b runs 0..NUM_BURSTS*BURST_BEATS-1 (32-bit).
  - WDATA = b replicated DW/32 times.
  - WLAST=1 when (b mod BURST_BEATS)=BURST_BEATS-1; with BURST_BEATS=1, WLAST is always 1.
  - WVALID/WDATA/WLAST are held stable until WREADY; WVALID=0 after the final beat.
- B channel:
  - BREADY permanently 1.
  - Each BVALID counts one response.
  - BRESP≠2'b00 sets write_error, which stays set until the next start.
  - A response arriving in IDLE is ignored.
- Simultaneous AW and W handshakes in the same cycle are both accepted.
- No outstanding-transaction limit; the slave throttles via AWREADY/WREADY.
- Reset mid-run: every output returns to its reset value on the next edge. The AXI slave must be reset in the same cycle; no drain is attempted.

Decomposition:
- Shared package holds AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11. It also holds a clog2-based AWSIZE helper function.
- One natural sub-module, `hbm_wdata_gen`: beat counter, pattern, WLAST and W handshake, with `start` / `done` ports. The AW issuer, B counter and timer stay in the top module.

Test Plan:
- Defaults, ideal slave → 16 AW handshakes at 0x0, 0x800, …, 0x7800; 1024 W beats with WLAST on beats 63, 127, …, 1023; write_time=1026; write_busy low afterwards; write_error=0.
- AWREADY low for 50 cycles, WREADY toggling 1/0 → AWADDR/WDATA stable while stalled; beat b carries {8{32'(b)}}; write_time = cycles busy; no beat lost or duplicated.
- BRESP=2'b10 on burst 5 of 16 → write_error=1 at run end. A subsequent start clears write_error to 0 and write_time to 0 on the start edge.
- start_write pulsed 3 times during a run → exactly 16 bursts issued; the run completes normally.
- reset asserted at beat 300 → next cycle write_busy=0, AWVALID=0, WVALID=0, write_time=0. A new start then runs cleanly from BASE_ADDR with b=0.
- BURST_BEATS=1, NUM_BURSTS=1, BASE_ADDR=0x1000 → one AW at 0x1000 with AWLEN=0; one beat with WLAST=1; write_time=3 with an ideal slave.
